// File: rtl/phase_packetizer_pkg.sv
// Shared constants and types for the phase sample packetizer: tag/length widths, descriptor
// layout, header field positions and egress FSM encodings.
package phase_packetizer_pkg;

  localparam int unsigned TAG_WIDTH    = 8;
  localparam int unsigned TAG_CATAGORY = 4;
  localparam int unsigned PKT_LEN      = 256;
  localparam int unsigned LEN_WIDTH    = $clog2(PKT_LEN + 1);

  // Header beat: tag at the bottom, 16-bit length field starting at lane 1.
  localparam int unsigned HDR_TAG_LSB  = 0;
  localparam int unsigned HDR_LEN_BITS = 16;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [LEN_WIDTH-1:0] len;
  } desc_t;

  localparam logic [1:0] EG_IDLE = 2'd0;
  localparam logic [1:0] EG_HDR  = 2'd1;
  localparam logic [1:0] EG_PAY  = 2'd2;

endpackage

// File: rtl/phase_packetizer_sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output; rdata always holds the oldest entry
// the cycle after it is written, so consumers can pop at one entry per cycle.
module phase_packetizer_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q, rptr_next;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] rdata_q;
  logic             do_push, do_pop;

  assign full    = count_q == (AW + 1)'(DEPTH);
  assign empty   = count_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rptr_next = rptr_q + AW'(do_pop);
  assign rdata   = rdata_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(do_push);
      rptr_q <= rptr_next;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Bypass keeps rdata equal to the new head when it is being written this cycle.
      if (do_push && (wptr_q == rptr_next)) begin
        rdata_q <= wdata;
      end else begin
        rdata_q <= mem_q[rptr_next];
      end
    end
  end

endmodule

// File: rtl/phase_packetizer.sv
// Frames a tagged sample-beat stream into AXIS packets: one header beat {tag, len} followed by
// the payload beats, closing on length limit, input tlast or tag change.
module phase_packetizer
  import phase_packetizer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned BEAT_SIZE    = 8,
  parameter int unsigned BUFFER_DEPTH = 512
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [BEAT_SIZE*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TAG_WIDTH-1:0]            s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [BEAT_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            err_drop
);
  localparam int unsigned BEAT_W = BEAT_SIZE * DATA_WIDTH;
  localparam logic [TAG_WIDTH-1:0] NUM_TAGS = TAG_WIDTH'(TAG_CATAGORY);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN  = LEN_WIDTH'(PKT_LEN);
  localparam logic [LEN_WIDTH-1:0] ONE      = LEN_WIDTH'(1);

  logic                 in_en_q, err_drop_q;
  logic [LEN_WIDTH-1:0] open_cnt_q, cnt_inc;
  logic [TAG_WIDTH-1:0] open_tag_q;
  logic                 tag_ok, tag_stall, accept, beat_ok, close_beat, close_stall;
  logic                 pay_full, pay_empty, pay_pop, desc_full, desc_empty, desc_push, desc_pop;
  logic [BEAT_W-1:0]    pay_head, hdr_beat;
  desc_t                desc_in, desc_head;

  logic [1:0]           state_q, state_d;
  logic [LEN_WIDTH-1:0] pay_left_q, pay_left_d;
  logic [BEAT_W-1:0]    tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d, tlast_q, tlast_d;

  // Ingest: a valid beat of a different tag stalls one cycle while the open packet is closed.
  assign tag_ok        = s_axis_tuser < NUM_TAGS;
  assign tag_stall     = s_axis_tvalid && tag_ok && (open_cnt_q != '0) &&
                         (s_axis_tuser != open_tag_q);
  assign s_axis_tready = in_en_q && !pay_full && !desc_full && !tag_stall;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign beat_ok       = accept && tag_ok;
  assign cnt_inc       = open_cnt_q + ONE;
  assign close_beat    = beat_ok && ((cnt_inc == MAX_LEN) || s_axis_tlast);
  assign close_stall   = tag_stall && in_en_q && !desc_full;
  assign desc_push     = close_beat || close_stall;
  assign desc_in.tag   = close_stall ? open_tag_q : s_axis_tuser;
  assign desc_in.len   = close_stall ? open_cnt_q : cnt_inc;

  phase_packetizer_sync_fifo #(
    .WIDTH(BEAT_W),
    .DEPTH(BUFFER_DEPTH)
  ) u_pay_fifo (
    .clk  (aclk),
    .rst  (areset),
    .push (beat_ok),
    .wdata(s_axis_tdata),
    .pop  (pay_pop),
    .rdata(pay_head),
    .full (pay_full),
    .empty(pay_empty)
  );

  phase_packetizer_sync_fifo #(
    .WIDTH($bits(desc_t)),
    .DEPTH(4)
  ) u_desc_fifo (
    .clk  (aclk),
    .rst  (areset),
    .push (desc_push),
    .wdata(desc_in),
    .pop  (desc_pop),
    .rdata(desc_head),
    .full (desc_full),
    .empty(desc_empty)
  );

  always_comb begin
    hdr_beat = '0;
    hdr_beat[HDR_TAG_LSB +: TAG_WIDTH]  = desc_head.tag;
    hdr_beat[DATA_WIDTH +: HDR_LEN_BITS] = HDR_LEN_BITS'(desc_head.len);
  end

  // Egress: the descriptor is popped once its header is taken, so the next descriptor is
  // already at the head when the last payload beat goes out (no bubble between packets).
  always_comb begin
    state_d    = state_q;
    pay_left_d = pay_left_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    pay_pop    = 1'b0;
    desc_pop   = 1'b0;
    case (state_q)
      EG_IDLE: begin
        if (!desc_empty) begin
          tdata_d  = hdr_beat;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          state_d  = EG_HDR;
        end
      end
      EG_HDR: begin
        if (m_axis_tready && !pay_empty) begin
          pay_pop    = 1'b1;
          desc_pop   = 1'b1;
          tdata_d    = pay_head;
          tlast_d    = desc_head.len == ONE;
          pay_left_d = desc_head.len - ONE;
          state_d    = EG_PAY;
        end
      end
      EG_PAY: begin
        if (m_axis_tready) begin
          if (pay_left_q != '0) begin
            pay_pop    = 1'b1;
            tdata_d    = pay_head;
            tlast_d    = pay_left_q == ONE;
            pay_left_d = pay_left_q - ONE;
          end else if (!desc_empty) begin
            tdata_d = hdr_beat;
            tlast_d = 1'b0;
            state_d = EG_HDR;
          end else begin
            tdata_d  = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = EG_IDLE;
          end
        end
      end
      default: state_d = EG_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      in_en_q    <= 1'b0;
      err_drop_q <= 1'b0;
      open_cnt_q <= '0;
      open_tag_q <= '0;
      state_q    <= EG_IDLE;
      pay_left_q <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      in_en_q    <= 1'b1;
      err_drop_q <= accept && !tag_ok;
      if (close_stall) begin
        open_cnt_q <= '0;
      end else if (beat_ok) begin
        open_cnt_q <= close_beat ? '0 : cnt_inc;
        open_tag_q <= s_axis_tuser;
      end
      state_q    <= state_d;
      pay_left_q <= pay_left_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign err_drop      = err_drop_q;

endmodule
